blackice_clock_supervisor: RTL and testbench

//  Supervises the board iCE40 PLL (100 MHz ref -> 25 MHz core): pulses PLL RESETB, waits for LOCK,

---
 rtl/blackice_clksup_pkg.sv | 38 +++
 rtl/blackice_sync_debounce.sv | 52 +++++
 rtl/blackice_clock_supervisor.sv | 171 +++++++++++++++++
 tb/tb_blackice_clock_supervisor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackice_clksup_pkg.sv
// Shared types and helpers for the BlackIce clock supervisor.
// State encodings double as the debug value driven on the state port.
package blackice_clksup_pkg;

    localparam logic [2:0] ENC_PLL_RST   = 3'd0;
    localparam logic [2:0] ENC_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ENC_STABLE    = 3'd2;
    localparam logic [2:0] ENC_SYS_UP    = 3'd3;
    localparam logic [2:0] ENC_RUN       = 3'd4;
    localparam logic [2:0] ENC_FAIL      = 3'd5;

    typedef enum logic [2:0] {
        ST_PLL_RST   = ENC_PLL_RST,
        ST_WAIT_LOCK = ENC_WAIT_LOCK,
        ST_STABLE    = ENC_STABLE,
        ST_SYS_UP    = ENC_SYS_UP,
        ST_RUN       = ENC_RUN,
        ST_FAIL      = ENC_FAIL
    } clksup_state_t;

    // Bits needed to hold max_value; never less than one bit.
    function automatic int width_for(input int max_value);
        if (max_value < 2) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/blackice_sync_debounce.sv
// N-flop synchronizer with an optional stable-count debouncer on its output.
// The debounced output only follows the synced input once it has differed for DEBOUNCE_CYCLES cycles.
module blackice_sync_debounce
    import blackice_clksup_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter bit   DEBOUNCE_EN     = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    if (DEBOUNCE_EN) begin : g_debounce
        localparam int DW = width_for(DEBOUNCE_CYCLES - 1);

        logic [DW-1:0] db_cnt;
        logic          db_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt <= '0;
                db_q   <= RESET_VAL;
            end else if (sync_q[STAGES-1] == db_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt <= '0;
                db_q   <= sync_q[STAGES-1];
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end

        assign dout = db_q;
    end else begin : g_direct
        assign dout = sync_q[STAGES-1];
    end

endmodule

// File: rtl/blackice_clock_supervisor.sv
// Sequences the iCE40 PLL out of reset and releases system then peripheral resets once lock is stable.
// Optional board button restart is enabled with BLACKICE_CLKSUP_BUTTON_EN.
module blackice_clock_supervisor
    import blackice_clksup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int PERIPH_DELAY   = 64,
    parameter int MAX_RETRIES    = 7,
    parameter int SYNC_STAGES    = 2
`ifdef BLACKICE_CLKSUP_BUTTON_EN
    ,
    parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pll_locked,
    output logic                              pll_resetb,
    output logic                              sys_reset,
    output logic                              periph_reset,
    output logic                              lock_fail,
    output logic [width_for(MAX_RETRIES)-1:0] retry_count,
    output logic [2:0]                        state
`ifdef BLACKICE_CLKSUP_BUTTON_EN
    ,
    input  logic                              btn_reset_n
`endif
);

    localparam int RW = width_for(MAX_RETRIES);
    localparam int CW = width_for(max_of4(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES, PERIPH_DELAY));

    clksup_state_t state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic [RW-1:0] retry_n;
    logic          lock_s;
    logic          btn_press;

    blackice_sync_debounce #(
        .STAGES      (SYNC_STAGES),
        .DEBOUNCE_EN (1'b0),
        .RESET_VAL   (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pll_locked),
        .dout  (lock_s)
    );

`ifdef BLACKICE_CLKSUP_BUTTON_EN
    logic btn_db, btn_prev;

    blackice_sync_debounce #(
        .STAGES          (2),
        .DEBOUNCE_EN     (1'b1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .din   (btn_reset_n),
        .dout  (btn_db)
    );

    // Only the falling edge of the debounced button restarts, so a held button acts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_db;
        end
    end

    assign btn_press = btn_prev & ~btn_db;
`else
    assign btn_press = 1'b0;
`endif

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign state   = state_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_inc;
        retry_n = retry_count;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_n = '0;
                    if (retry_count == RW'(MAX_RETRIES)) begin
                        state_n = ST_FAIL;
                    end else begin
                        retry_n = retry_count + RW'(1);
                        state_n = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                // A dropout here is treated as a glitch and does not consume a retry.
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_n = ST_SYS_UP;
                    cnt_n   = '0;
                end
            end
            ST_SYS_UP: begin
                if (!lock_s) begin
                    state_n = ST_PLL_RST;
                    cnt_n   = '0;
                end else if (cnt_q == CW'(PERIPH_DELAY - 1)) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_n = ST_PLL_RST;
                    cnt_n   = '0;
                end
            end
            ST_FAIL: begin
                cnt_n = cnt_q;
            end
            default: begin
                state_n = ST_PLL_RST;
                cnt_n   = '0;
            end
        endcase
        if (btn_press) begin
            state_n = ST_PLL_RST;
            cnt_n   = '0;
            retry_n = '0;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            retry_count  <= '0;
            pll_resetb   <= 1'b0;
            sys_reset    <= 1'b1;
            periph_reset <= 1'b1;
            lock_fail    <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            retry_count  <= retry_n;
            pll_resetb   <= (state_n != ST_PLL_RST);
            sys_reset    <= !((state_n == ST_SYS_UP) || (state_n == ST_RUN));
            periph_reset <= (state_n != ST_RUN);
            lock_fail    <= (state_n == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_blackice_clock_supervisor.sv
// Scoreboard bench for blackice_clock_supervisor: every output change and checkpoint is queued with its cycle.
// Button scenarios run only when BLACKICE_CLKSUP_BUTTON_EN is defined.
module tb_blackice_clock_supervisor;
    import blackice_clksup_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       prb;
        logic       sr;
        logic       pr;
        logic       lf;
        logic [1:0] rc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_resetb;
    logic       sys_reset;
    logic       periph_reset;
    logic       lock_fail;
    logic [1:0] retry_count;
    logic [2:0] state;
`ifdef BLACKICE_CLKSUP_BUTTON_EN
    logic       btn_reset_n;
`endif

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    logic [8:0] prev_out;

    blackice_clock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .PERIPH_DELAY   (3),
        .MAX_RETRIES    (2),
        .SYNC_STAGES    (2)
`ifdef BLACKICE_CLKSUP_BUTTON_EN
        ,
        .DEBOUNCE_CYCLES (16)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .pll_resetb   (pll_resetb),
        .sys_reset    (sys_reset),
        .periph_reset (periph_reset),
        .lock_fail    (lock_fail),
        .retry_count  (retry_count),
        .state        (state)
`ifdef BLACKICE_CLKSUP_BUTTON_EN
        ,
        .btn_reset_n  (btn_reset_n)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input exp_t e);
        checks++;
        if (state !== e.st || pll_resetb !== e.prb || sys_reset !== e.sr || periph_reset !== e.pr ||
            lock_fail !== e.lf || retry_count !== e.rc) begin
            errors++;
            $display("[TB] FAIL outputs@%0d: got st=%0d prb=%b sr=%b pr=%b lf=%b rc=%0d, required st=%0d prb=%b sr=%b pr=%b lf=%b rc=%0d",
                     cyc, state, pll_resetb, sys_reset, periph_reset, lock_fail, retry_count,
                     e.st, e.prb, e.sr, e.pr, e.lf, e.rc);
        end
    endtask

    // Monitor: compares at each queued cycle and flags any output change nobody predicted.
    always @(posedge clk) begin
        logic [8:0] cur;
        #1;
        cur = {state, pll_resetb, sys_reset, periph_reset, lock_fail, retry_count};
        if (mon_en) begin
            checks++;
            if (!periph_reset && sys_reset) begin
                errors++;
                $display("[TB] FAIL reset_order@%0d: periph_reset=%b while sys_reset=%b, required periph_reset=1",
                         cyc, periph_reset, sys_reset);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed@%0d: expectation for cycle %0d not reached, required on time",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check_output(exp_q.pop_front());
            end else if (cur !== prev_out) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_change@%0d: outputs %h, required unchanged %h", cyc, cur, prev_out);
            end
        end
        prev_out = cur;
    end

    task automatic expect_at(input int c, input logic [2:0] st, input logic prb, input logic sr,
                             input logic pr, input logic lf, input logic [1:0] rc);
        exp_t e;
        e.cyc = c; e.st = st; e.prb = prb; e.sr = sr; e.pr = pr; e.lf = lf; e.rc = rc;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Reset on the next edge r, released at the following negedge; returns r.
    task automatic do_reset(input logic lk, output int r);
        @(negedge clk);
        reset      = 1'b1;
        pll_locked = lk;
        r = cyc + 1;
        expect_at(r, ST_PLL_RST, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Lock already synced: 4 cycles of PLL reset, 1 in WAIT_LOCK, 8 in STABLE, 3 in SYS_UP.
    task automatic push_bringup(input int b);
        expect_at(b + 4,  ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        expect_at(b + 5,  ST_STABLE,    1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        expect_at(b + 13, ST_SYS_UP,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_at(b + 16, ST_RUN,       1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Lock never arrives: timeouts every 24 cycles, third one lands in FAIL at +72.
    task automatic push_timeouts(input int r);
        expect_at(r + 4, ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 2; k++) begin
            expect_at(r + 24 * k,     ST_PLL_RST,   1'b0, 1'b1, 1'b1, 1'b0, 2'(k));
            expect_at(r + 24 * k + 4, ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'(k));
        end
        expect_at(r + 72, ST_FAIL, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 1500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input int test_id);
        int r;
        int r2;
        case (test_id)
            1: begin
                do_reset(1'b1, r);
                push_bringup(r);
                expect_at(r + 30, ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            end
            2: begin
                do_reset(1'b0, r);
                push_timeouts(r);
                expect_at(r + 1072, ST_FAIL, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
            end
            3: begin
                do_reset(1'b1, r);
                expect_at(r + 4, ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                expect_at(r + 5, ST_STABLE,    1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                push_bringup(r + 7);
                expect_at(r + 35, ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                wait_cyc(r + 8);
                pll_locked = 1'b0;
                wait_cyc(r + 9);
                pll_locked = 1'b1;
            end
            4: begin
                do_reset(1'b1, r);
                push_bringup(r);
                expect_at(r + 23, ST_PLL_RST, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
                push_bringup(r + 23);
                expect_at(r + 48, ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                wait_cyc(r + 20);
                pll_locked = 1'b0;
                wait_cyc(r + 23);
                pll_locked = 1'b1;
            end
            5: begin
                do_reset(1'b1, r);
                r2 = r + 15;
                expect_at(r + 4,  ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                expect_at(r + 5,  ST_STABLE,    1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                expect_at(r + 13, ST_SYS_UP,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
                expect_at(r2,     ST_PLL_RST,   1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
                push_bringup(r2);
                expect_at(r2 + 25, ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                wait_cyc(r + 14);
                reset = 1'b1;
                wait_cyc(r + 15);
                reset = 1'b0;
            end
`ifdef BLACKICE_CLKSUP_BUTTON_EN
            6: begin
                // 10-cycle glitch ignored, 20-cycle press seen 19 edges after it starts.
                do_reset(1'b1, r);
                push_bringup(r);
                expect_at(r + 59, ST_PLL_RST, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
                push_bringup(r + 59);
                expect_at(r + 90, ST_RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                wait_cyc(r + 20);
                btn_reset_n = 1'b0;
                wait_cyc(r + 30);
                btn_reset_n = 1'b1;
                wait_cyc(r + 40);
                btn_reset_n = 1'b0;
                wait_cyc(r + 60);
                btn_reset_n = 1'b1;
            end
            7: begin
                do_reset(1'b0, r);
                push_timeouts(r);
                expect_at(r + 99,  ST_PLL_RST,   1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
                expect_at(r + 103, ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                expect_at(r + 110, ST_WAIT_LOCK, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
                wait_cyc(r + 80);
                btn_reset_n = 1'b0;
                wait_cyc(r + 100);
                btn_reset_n = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        wait_drain();
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
`ifdef BLACKICE_CLKSUP_BUTTON_EN
        btn_reset_n = 1'b1;
`endif
        for (int t = 1; t <= 5; t++) begin
            $display("[TB] scenario %0d", t);
            apply_stimulus(t);
        end
`ifdef BLACKICE_CLKSUP_BUTTON_EN
        for (int t = 6; t <= 7; t++) begin
            $display("[TB] scenario %0d", t);
            apply_stimulus(t);
        end
`endif
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
